// File: rtl/full_sub_pkg.sv
// rtl/full_sub_pkg.sv - shared constants and reference function for the ripple-borrow subtractor
package full_sub_pkg;

    localparam int DEFAULT_WIDTH = 1;

    // Returns {bout, d} in 65 bits: d is masked to width, and bout sits at bit 64.
    // The operands are zero-extended, so bit 64 of the raw result is the borrow.
    function automatic logic [64:0] ref_sub(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic        bin,
                                            input int unsigned width);
        logic [64:0] full;
        logic [63:0] mask;
        full = {1'b0, a} - {1'b0, b} - 65'(bin);
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return {full[64], full[63:0] & mask};
    endfunction

endpackage

// File: rtl/full_sub_if.sv
// rtl/full_sub_if.sv - operand/result bundle for full_sub
interface full_sub_if
    import full_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;

    modport master (output in_valid, a, b, bin, input out_valid, d, bout, zero);
    modport slave  (input in_valid, a, b, bin, output out_valid, d, bout, zero);
endinterface

// File: rtl/full_sub_cell.sv
// rtl/full_sub_cell.sv - combinational 1-bit full subtractor
module full_sub_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

// File: rtl/full_sub.sv
// rtl/full_sub.sv - registered WIDTH-bit ripple-borrow subtractor, d = a - b - bin
module full_sub
    import full_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    full_sub_if.slave bus
);
    logic [WIDTH:0]   br;
    logic [WIDTH-1:0] diff;

    assign br[0] = bus.bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_sub_cell u_cell (
            .a_i   (bus.a[i]),
            .b_i   (bus.b[i]),
            .bin_i (br[i]),
            .d_o   (diff[i]),
            .bout_o(br[i+1])
        );
    end

    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    // Result registers only load on a valid operand; otherwise they hold.
    always_comb begin
        d_d     = d_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        valid_d = bus.in_valid;
        if (bus.in_valid) begin
            d_d    = diff;
            bout_d = br[WIDTH];
            zero_d = ~|diff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            d_q     <= d_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_full_sub.sv
// tb/tb_full_sub.sv - randomized and directed self-checking bench for full_sub
module tb_full_sub;
    import full_sub_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    full_sub_if #(.WIDTH(1))  if1 ();
    full_sub_if #(.WIDTH(8))  if8 ();
    full_sub_if #(.WIDTH(16)) if16 ();

    full_sub #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    full_sub #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    full_sub #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain signed arithmetic view of a - b - bin, wrapped to w bits.
    task automatic model(input longint unsigned a, input longint unsigned b, input bit bin,
                         input int w, output longint unsigned d, output bit bout);
        longint s;
        s    = longint'(a) - longint'(b) - longint'(bin);
        bout = (s < 0);
        d    = longint'(s + (longint'(1) << w)) % (longint'(1) << w);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        if8.in_valid = 1'b1;
        if8.a        = a;
        if8.b        = b;
        if8.bin      = bin;
        tick();
        if8.in_valid = 1'b0;
    endtask

    logic [1:0]  tt [8];
    logic [7:0]  da [4];
    logic [7:0]  db [4];
    logic        dbin [4];
    logic [7:0]  ed [4];
    logic        eb [4];
    logic        ez [4];

    initial begin
        longint unsigned md, last_d;
        bit              mb, last_b, v;
        logic [15:0]     ra, rb;
        logic            rbin;
        logic [64:0]     pr;

        // (d, bout) for a,b,bin = 000..111
        tt[0] = 2'b00; tt[1] = 2'b11; tt[2] = 2'b11; tt[3] = 2'b01;
        tt[4] = 2'b10; tt[5] = 2'b00; tt[6] = 2'b00; tt[7] = 2'b11;
        da[0] = 8'h00; db[0] = 8'h01; dbin[0] = 1'b0; ed[0] = 8'hFF; eb[0] = 1'b1; ez[0] = 1'b0;
        da[1] = 8'h05; db[1] = 8'h05; dbin[1] = 1'b0; ed[1] = 8'h00; eb[1] = 1'b0; ez[1] = 1'b1;
        da[2] = 8'h10; db[2] = 8'h0F; dbin[2] = 1'b1; ed[2] = 8'h00; eb[2] = 1'b0; ez[2] = 1'b1;
        da[3] = 8'h10; db[3] = 8'h10; dbin[3] = 1'b1; ed[3] = 8'hFF; eb[3] = 1'b1; ez[3] = 1'b0;

        if1.in_valid = 0;  if1.a = '0;  if1.b = '0;  if1.bin = 0;
        if8.in_valid = 0;  if8.a = '0;  if8.b = '0;  if8.bin = 0;
        if16.in_valid = 0; if16.a = '0; if16.b = '0; if16.bin = 0;

        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid1", 64'(if1.out_valid), 0);
        check("rst_d8", 64'(if8.d), 0);
        check("rst_bout8", 64'(if8.bout), 0);
        check("rst_zero8", 64'(if8.zero), 0);
        check("rst_valid16", 64'(if16.out_valid), 0);
        rst_n = 1'b1;

        // Exhaustive 1-bit sweep, back to back
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v3;
            v3 = 3'(i);
            if1.in_valid = 1'b1;
            if1.a   = v3[2];
            if1.b   = v3[1];
            if1.bin = v3[0];
            tick();
            check($sformatf("w1_valid_%0d", i), 64'(if1.out_valid), 1);
            check($sformatf("w1_d_%0d", i), 64'(if1.d), 64'(tt[i][1]));
            check($sformatf("w1_bout_%0d", i), 64'(if1.bout), 64'(tt[i][0]));
        end
        if1.in_valid = 1'b0;

        // 8-bit wrap-around and borrow-in edges
        for (int i = 0; i < 4; i++) begin
            op8(da[i], db[i], dbin[i]);
            check($sformatf("w8_valid_%0d", i), 64'(if8.out_valid), 1);
            check($sformatf("w8_d_%0d", i), 64'(if8.d), 64'(ed[i]));
            check($sformatf("w8_bout_%0d", i), 64'(if8.bout), 64'(eb[i]));
            check($sformatf("w8_zero_%0d", i), 64'(if8.zero), 64'(ez[i]));
        end

        // Hold: idle cycles with junk operands must not disturb the result
        op8(8'd9, 8'd3, 1'b0);
        check("hold_d0", 64'(if8.d), 6);
        for (int i = 0; i < 3; i++) begin
            if8.a   = 8'($urandom);
            if8.b   = 8'($urandom);
            if8.bin = 1'($urandom);
            tick();
            check($sformatf("hold_valid_%0d", i), 64'(if8.out_valid), 0);
            check($sformatf("hold_d_%0d", i), 64'(if8.d), 6);
        end

        // Asynchronous reset between edges
        op8(8'h20, 8'h01, 1'b0);
        check("mid_pre_valid", 64'(if8.out_valid), 1);
        check("mid_pre_d", 64'(if8.d), 64'h1F);
        #2 rst_n = 1'b0;
        #1;
        check("mid_valid", 64'(if8.out_valid), 0);
        check("mid_d", 64'(if8.d), 0);
        check("mid_bout", 64'(if8.bout), 0);
        rst_n = 1'b1;
        op8(8'h03, 8'h07, 1'b1);
        check("post_valid", 64'(if8.out_valid), 1);
        check("post_d", 64'(if8.d), 64'hFB);
        check("post_bout", 64'(if8.bout), 1);

        // Random 16-bit regression
        last_d = 0;
        last_b = 0;
        for (int n = 0; n < 1000; n++) begin
            v    = 1'($urandom_range(0, 3) != 0);
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            if (n % 50 == 0) rb = ra;
            if16.in_valid = v;
            if16.a   = ra;
            if16.b   = rb;
            if16.bin = rbin;
            if (v) begin
                model(64'(ra), 64'(rb), rbin, 16, md, mb);
                last_d = md;
                last_b = mb;
                pr = ref_sub(64'(ra), 64'(rb), rbin, 16);
                check("pkg_ref", 64'({pr[64], pr[15:0]}), 64'({mb, md[15:0]}));
            end
            tick();
            check("rnd_valid", 64'(if16.out_valid), 64'(v));
            check("rnd_d", 64'(if16.d), last_d);
            check("rnd_bout", 64'(if16.bout), 64'(last_b));
            if (v) check("rnd_zero", 64'(if16.zero), 64'(last_d == 0));
        end
        if16.in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
